// File: rtl/fake_rd_pkg.sv
// Shared types for the fake readout block: FSM states and data-source modes.
package fake_rd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DELAY = 3'd1,
    ST_PRE   = 3'd2,
    ST_XFER  = 3'd3,
    ST_TAIL  = 3'd4
  } rd_state_e;

  typedef enum logic [1:0] {
    MODE_REPLAY = 2'd0,
    MODE_RAMP   = 2'd1,
    MODE_CONST  = 2'd2,
    MODE_MIXED  = 2'd3
  } rd_mode_e;

endpackage

// File: rtl/rd_ring_ram.sv
// Simple dual-port capture buffer, one write and one registered read port.
module rd_ring_ram #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 2048
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/fake_rd_nch.sv
// Multi-channel fake ADC readout: captures samples into ring buffers and, on a
// trigger, serialises DEPTH words per channel with odd parity after a preamble.
module fake_rd_nch
  import fake_rd_pkg::*;
#(
  parameter int NCH      = 2,
  parameter int WIDTH    = 12,
  parameter int DEPTH    = 2048,
  parameter int TRIG_DLY = 20,
  parameter int PRE_CYC  = 3,
  parameter int TAIL_CYC = 12
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     ENABLE,
  input  logic                     TRIGGER,
  input  logic [1:0]               MODE,
  input  logic [WIDTH-1:0]         PATTERN,
  input  logic [NCH*WIDTH-1:0]     ADC_DATA,
  input  logic                     CAPT_VALID,
  output logic [NCH-1:0]           SERIAL_OUT,
  output logic                     XFR_EN,
  output logic                     BUSY,
  output logic                     DONE,
  output logic [$clog2(DEPTH):0]   WORD_CNT
);

  localparam int AW = $clog2(DEPTH);
  localparam int BW = $clog2(WIDTH + 1);
  localparam int unsigned LAST_WORD = DEPTH - 1;

  rd_state_e        state_q, state_d;
  rd_mode_e         mode_q, mode_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]      word_cnt_q, word_cnt_d;
  logic [WIDTH-1:0] pattern_q, pattern_d;
  logic             trig_q, trig_qq;
  logic [WIDTH:0]   sreg_q [NCH];
  logic [WIDTH:0]   sreg_d [NCH];
  logic [WIDTH-1:0] rd_data [NCH];
  logic [WIDTH-1:0] next_word [NCH];
  logic [WIDTH-1:0] ramp_idx, ramp_word;
  logic             we, trig_edge, load_word;

  for (genvar k = 0; k < NCH; k++) begin : g_ram
    rd_ring_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ram (
      .clk   (CLK),
      .we    (we),
      .waddr (wptr_q),
      .wdata (ADC_DATA[k*WIDTH +: WIDTH]),
      .raddr (rptr_q),
      .rdata (rd_data[k])
    );
  end

  // Word about to be loaded: index 0 during the preamble prefetch, else the one after the current.
  always_comb begin
    ramp_idx  = (state_q == ST_PRE) ? '0 : WIDTH'(word_cnt_q + 1'b1);
    ramp_word = '0 - ramp_idx;
    for (int k = 0; k < NCH; k++) begin
      case (mode_q)
        MODE_REPLAY: next_word[k] = rd_data[k];
        MODE_RAMP:   next_word[k] = ramp_word;
        MODE_CONST:  next_word[k] = pattern_q;
        MODE_MIXED:  next_word[k] = (k == 0) ? rd_data[k] : ramp_word;
        default:     next_word[k] = rd_data[k];
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    word_cnt_d = word_cnt_q;
    pattern_d  = pattern_q;
    sreg_d     = sreg_q;
    we         = 1'b0;
    load_word  = 1'b0;
    DONE       = 1'b0;
    trig_edge  = trig_q & ~trig_qq;

    if (!ENABLE) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      bit_d   = '0;
      if (state_q != ST_IDLE) wptr_d = '0;
    end else begin
      we = CAPT_VALID && (state_q == ST_IDLE || state_q == ST_DELAY);
      if (we) wptr_d = wptr_q + 1'b1;
      unique case (state_q)
        ST_IDLE: begin
          if (trig_edge) begin
            state_d    = ST_DELAY;
            cnt_d      = '0;
            word_cnt_d = '0;
          end
        end
        ST_DELAY: begin
          if (cnt_q == 16'(TRIG_DLY - 1)) begin
            state_d   = ST_PRE;
            cnt_d     = '0;
            rptr_d    = wptr_d;
            mode_d    = rd_mode_e'(MODE);
            pattern_d = PATTERN;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        ST_PRE: begin
          if (cnt_q == 16'(PRE_CYC - 1)) begin
            state_d   = ST_XFER;
            cnt_d     = '0;
            bit_d     = '0;
            load_word = 1'b1;
            rptr_d    = rptr_q + 1'b1;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        ST_XFER: begin
          if (bit_q == BW'(WIDTH)) begin
            bit_d      = '0;
            word_cnt_d = word_cnt_q + 1'b1;
            if (word_cnt_q == LAST_WORD[AW:0]) begin
              state_d = ST_TAIL;
              cnt_d   = '0;
            end else begin
              load_word = 1'b1;
              rptr_d    = rptr_q + 1'b1;
            end
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
        ST_TAIL: begin
          if (cnt_q == 16'(TAIL_CYC - 1)) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            DONE    = 1'b1;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Parity sits below the data so a plain left shift emits MSB..LSB then parity.
    for (int k = 0; k < NCH; k++) begin
      if (load_word)
        sreg_d[k] = {next_word[k], ~^next_word[k]};
      else if (state_q == ST_XFER)
        sreg_d[k] = {sreg_q[k][WIDTH-1:0], 1'b1};
    end
  end

  // Edge history resets high so a TRIGGER already high at reset release is not an edge.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q    <= ST_IDLE;
      mode_q     <= MODE_REPLAY;
      cnt_q      <= '0;
      bit_q      <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      word_cnt_q <= '0;
      pattern_q  <= '0;
      trig_q     <= 1'b1;
      trig_qq    <= 1'b1;
      for (int k = 0; k < NCH; k++) sreg_q[k] <= '1;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      word_cnt_q <= word_cnt_d;
      pattern_q  <= pattern_d;
      trig_q     <= TRIGGER;
      trig_qq    <= trig_q;
      sreg_q     <= sreg_d;
    end
  end

  always_comb begin
    for (int k = 0; k < NCH; k++)
      SERIAL_OUT[k] = (state_q == ST_XFER) ? sreg_q[k][WIDTH] : 1'b1;
    XFR_EN   = (state_q == ST_PRE) || (state_q == ST_XFER) || (state_q == ST_TAIL);
    BUSY     = (state_q != ST_IDLE);
    WORD_CNT = word_cnt_q;
  end

endmodule

// File: tb/tb_fake_rd_nch.sv
// Directed self-checking bench for fake_rd_nch with a 16-word buffer.
module tb_fake_rd_nch;

  localparam int NCH      = 2;
  localparam int WIDTH    = 12;
  localparam int DEPTH    = 16;
  localparam int TRIG_DLY = 20;
  localparam int PRE_CYC  = 3;
  localparam int TAIL_CYC = 12;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        trigger;
  logic [1:0]  mode;
  logic [11:0] pattern;
  logic [23:0] adc_data;
  logic        capt_valid;
  logic [1:0]  serial_out;
  logic        xfr_en;
  logic        busy;
  logic        done;
  logic [4:0]  word_cnt;

  int          errors = 0;
  int          checks = 0;
  int          doneCnt;
  logic        firstPar0;
  logic [11:0] exp0 [16];
  logic [11:0] exp1 [16];

  fake_rd_nch #(
    .NCH(NCH), .WIDTH(WIDTH), .DEPTH(DEPTH),
    .TRIG_DLY(TRIG_DLY), .PRE_CYC(PRE_CYC), .TAIL_CYC(TAIL_CYC)
  ) dut (
    .CLK        (clk),
    .RST_N      (rst_n),
    .ENABLE     (enable),
    .TRIGGER    (trigger),
    .MODE       (mode),
    .PATTERN    (pattern),
    .ADC_DATA   (adc_data),
    .CAPT_VALID (capt_valid),
    .SERIAL_OUT (serial_out),
    .XFR_EN     (xfr_en),
    .BUSY       (busy),
    .DONE       (done),
    .WORD_CNT   (word_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Writes n consecutive samples, each channel counting up from its base.
  task automatic applyStimulus(input int n, input logic [11:0] base0, input logic [11:0] base1);
    for (int i = 0; i < n; i++) begin
      adc_data   = {base1 + 12'(i), base0 + 12'(i)};
      capt_valid = 1'b1;
      tick();
    end
    capt_valid = 1'b0;
  endtask

  task automatic startTransfer(input string tag);
    int n;
    n = 0;
    trigger = 1'b1;
    while (xfr_en !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    trigger = 1'b0;
    checkOutput({tag, "/latency"}, n, TRIG_DLY + 2);
    checkOutput({tag, "/pre_lines"}, serial_out, 2'b11);
    repeat (PRE_CYC) tick();
  endtask

  task automatic receiveWords(input string tag, input bit retrig, input bit chg);
    logic [12:0] sh0, sh1;
    int tailEn, badLines, busyCnt;
    doneCnt = 0;
    for (int w = 0; w < 16; w++) begin
      sh0 = '0;
      sh1 = '0;
      for (int b = 0; b < 13; b++) begin
        if (retrig && w == 3 && b == 0) trigger = 1'b1;
        if (retrig && w == 5 && b == 0) trigger = 1'b0;
        if (chg && w == 1 && b == 0) begin
          mode    = 2'd0;
          pattern = 12'h000;
        end
        sh0 = {sh0[11:0], serial_out[0]};
        sh1 = {sh1[11:0], serial_out[1]};
        if (done) doneCnt++;
        tick();
      end
      if (w == 0) firstPar0 = sh0[0];
      checkOutput($sformatf("%s/ch0_word%0d", tag, w), sh0, {exp0[w], ~^exp0[w]});
      checkOutput($sformatf("%s/ch1_word%0d", tag, w), sh1, {exp1[w], ~^exp1[w]});
    end
    tailEn   = 0;
    badLines = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) doneCnt++;
      if (xfr_en) tailEn++;
      if (serial_out !== 2'b11) badLines++;
      tick();
    end
    checkOutput({tag, "/done_count"}, doneCnt, 1);
    checkOutput({tag, "/tail_cycles"}, tailEn, TAIL_CYC);
    checkOutput({tag, "/tail_lines"}, badLines, 0);
    checkOutput({tag, "/word_cnt"}, word_cnt, 16);
    checkOutput({tag, "/busy_end"}, busy, 1'b0);
    if (retrig) begin
      busyCnt = 0;
      for (int i = 0; i < 40; i++) begin
        if (busy) busyCnt++;
        tick();
      end
      checkOutput({tag, "/no_queued_xfer"}, busyCnt, 0);
    end
  endtask

  initial begin
    int busyCnt;
    rst_n      = 1'b0;
    enable     = 1'b1;
    trigger    = 1'b1;
    capt_valid = 1'b0;
    mode       = 2'd0;
    pattern    = 12'h000;
    adc_data   = '0;
    tick();
    tick();
    checkOutput("reset/serial_out", serial_out, 2'b11);
    checkOutput("reset/xfr_en", xfr_en, 1'b0);
    checkOutput("reset/busy", busy, 1'b0);
    checkOutput("reset/done", done, 1'b0);
    checkOutput("reset/word_cnt", word_cnt, 0);

    rst_n   = 1'b1;
    busyCnt = 0;
    for (int i = 0; i < 30; i++) begin
      if (busy) busyCnt++;
      tick();
    end
    checkOutput("reset/trigger_high_no_edge", busyCnt, 0);
    trigger = 1'b0;
    tick();
    tick();

    $display("[TB] replay of 16 captured samples");
    applyStimulus(16, 12'h000, 12'h100);
    for (int i = 0; i < 16; i++) begin
      exp0[i] = 12'(i);
      exp1[i] = 12'h100 + 12'(i);
    end
    mode = 2'd0;
    startTransfer("replay");
    receiveWords("replay", 1'b0, 1'b0);

    $display("[TB] replay after 20 captures wraps");
    applyStimulus(20, 12'h200, 12'h300);
    for (int i = 0; i < 16; i++) begin
      exp0[i] = 12'h204 + 12'(i);
      exp1[i] = 12'h304 + 12'(i);
    end
    startTransfer("wrap");
    receiveWords("wrap", 1'b0, 1'b0);

    $display("[TB] down-ramp with retrigger mid-transfer");
    mode = 2'd1;
    for (int i = 0; i < 16; i++) begin
      exp0[i] = 12'(0 - i);
      exp1[i] = 12'(0 - i);
    end
    startTransfer("ramp");
    receiveWords("ramp", 1'b1, 1'b0);

    $display("[TB] constant pattern, mode/pattern changed mid-transfer");
    mode    = 2'd2;
    pattern = 12'hA5A;
    for (int i = 0; i < 16; i++) begin
      exp0[i] = 12'hA5A;
      exp1[i] = 12'hA5A;
    end
    startTransfer("const");
    receiveWords("const", 1'b0, 1'b1);
    checkOutput("const/parity_bit", firstPar0, 1'b1);

    $display("[TB] mixed: ch0 replay, ch1 ramp");
    mode = 2'd3;
    for (int i = 0; i < 16; i++) begin
      exp0[i] = 12'h204 + 12'(i);
      exp1[i] = 12'(0 - i);
    end
    startTransfer("mixed");
    receiveWords("mixed", 1'b0, 1'b0);

    $display("[TB] enable dropped at word 5");
    mode = 2'd1;
    for (int i = 0; i < 16; i++) begin
      exp0[i] = 12'(0 - i);
      exp1[i] = 12'(0 - i);
    end
    startTransfer("abort");
    repeat (5 * 13 + 4) tick();
    enable = 1'b0;
    tick();
    checkOutput("abort/busy", busy, 1'b0);
    checkOutput("abort/xfr_en", xfr_en, 1'b0);
    checkOutput("abort/serial_out", serial_out, 2'b11);
    checkOutput("abort/done", done, 1'b0);
    checkOutput("abort/word_cnt", word_cnt, 5);
    doneCnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) doneCnt++;
      tick();
    end
    checkOutput("abort/no_done", doneCnt, 0);
    enable = 1'b1;
    tick();
    tick();
    startTransfer("after_abort");
    receiveWords("after_abort", 1'b0, 1'b0);

    $display("[TB] reset pulse mid-transfer");
    mode = 2'd2;
    startTransfer("rst_mid");
    repeat (30) tick();
    rst_n = 1'b0;
    tick();
    checkOutput("rst_mid/serial_out", serial_out, 2'b11);
    checkOutput("rst_mid/xfr_en", xfr_en, 1'b0);
    checkOutput("rst_mid/busy", busy, 1'b0);
    checkOutput("rst_mid/done", done, 1'b0);
    checkOutput("rst_mid/word_cnt", word_cnt, 0);
    rst_n = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
